ccff_bitstream_loader: RTL

Drives the configuration-chain head (`ccff_head`) of a tile column and consumes its far end (`ccff_tail`). It receives bitstream words over a valid/ready stream and serializes them MSB-first into the chain. It generates the per-cycle shift enable for the chain's external clock gate, so a load can stall without corrupting chain contents. With the check feature compiled in, it shifts a known preamble ahead of the data and verifies that the preamble emerges at `ccff_tail` after exactly `CHAIN_LEN` shifts, which proves chain continuity and length.

---
 rtl/ccff_bitstream_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: streams 32-bit words MSB-first into a configuration chain with a gated shift enable.
// Define CCFF_LOADER_CHECK_EN to shift PREAMBLE ahead of the data and verify it at the chain tail.
module ccff_bitstream_loader #(
  parameter int unsigned CHAIN_LEN = 1024,
  parameter logic [31:0] PREAMBLE  = 32'hA5C3_3C5A
) (
  input  logic        i_prog_clk,
  input  logic        i_prog_reset_n,
  input  logic        i_start,
  input  logic [31:0] i_bit_data,
  input  logic        i_bit_valid,
  output logic        o_bit_ready,
  output logic        o_ccff_head,
  output logic        o_ccff_shift_en,
  input  logic        i_ccff_tail,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_check_fail
);
`ifdef CCFF_LOADER_CHECK_EN
  localparam int unsigned PRE_LEN = 32;
`else
  localparam int unsigned PRE_LEN = 0;
`endif
  localparam int unsigned TOTAL = CHAIN_LEN + PRE_LEN;
  localparam int unsigned NW    = (CHAIN_LEN + 31) / 32;
  localparam int CW = $clog2(TOTAL + 2);
  localparam int WW = $clog2(NW + 2);
  localparam logic [CW-1:0] L_TOT  = CW'(TOTAL);
  localparam logic [CW-1:0] L_LAST = CW'(TOTAL - 1);
  typedef enum logic [1:0] {IDLE, PRE, LOAD, DONE} state_t;
  localparam state_t S_FIRST = (PRE_LEN != 0) ? PRE : LOAD;
  state_t r_state, w_state_nxt;
  logic [31:0]   r_sr, r_buf;
  logic [5:0]    r_sr_cnt;
  logic          r_buf_vld;
  logic [WW-1:0] r_words;
  logic [CW-1:0] r_cnt, w_iss;
  logic          r_head, r_shift_en, r_check_fail;
  logic          w_active, w_start, w_acc, w_issue, w_last, w_miss;
  assign w_active        = (r_state == PRE) || (r_state == LOAD);
  assign w_start         = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign o_bit_ready     = w_active && !r_buf_vld && (r_words < WW'(NW));
  assign w_acc           = i_bit_valid && o_bit_ready;
  // bits already placed on the head: completed shifts plus the one in flight
  assign w_iss           = r_cnt + CW'(r_shift_en);
  assign w_issue         = w_active && (w_iss < L_TOT) && ((r_sr_cnt != 6'd0) || r_buf_vld);
  assign w_last          = r_shift_en && (r_cnt == L_LAST);
  assign o_ccff_head     = r_head;
  assign o_ccff_shift_en = r_shift_en;
  assign o_busy          = w_active;
  assign o_done          = r_state == DONE;
  assign o_check_fail    = r_check_fail;
`ifdef CCFF_LOADER_CHECK_EN
  localparam logic [CW-1:0] L_CHAIN = CW'(CHAIN_LEN);
  logic [CW-1:0] w_off;
  assign w_off  = r_cnt - L_CHAIN;
  // the preamble bit shifted (w_off+1)-th should be leaving the last flop now
  assign w_miss = r_shift_en && (r_cnt >= L_CHAIN) && (w_off < CW'(32)) && (i_ccff_tail != PREAMBLE[~w_off[4:0]]);
`else
  logic [31:0] w_unused;
  assign w_unused = PREAMBLE ^ {31'b0, i_ccff_tail};
  assign w_miss   = 1'b0;
`endif
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) w_state_nxt = S_FIRST;
    else if (w_last) w_state_nxt = DONE;
    else if ((r_state == PRE) && w_issue && (r_sr_cnt == 6'd1)) w_state_nxt = LOAD;
  end
  always_ff @(posedge i_prog_clk or negedge i_prog_reset_n)
    if (!i_prog_reset_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_ff @(posedge i_prog_clk or negedge i_prog_reset_n)
    if (!i_prog_reset_n) begin
      r_sr         <= '0;
      r_buf        <= '0;
      r_sr_cnt     <= '0;
      r_buf_vld    <= 1'b0;
      r_words      <= '0;
      r_cnt        <= '0;
      r_head       <= 1'b0;
      r_shift_en   <= 1'b0;
      r_check_fail <= 1'b0;
    end else if (w_start) begin
      r_buf        <= '0;
      r_buf_vld    <= 1'b0;
      r_words      <= '0;
      r_cnt        <= '0;
      r_check_fail <= 1'b0;
`ifdef CCFF_LOADER_CHECK_EN
      r_sr         <= PREAMBLE << 1;
      r_sr_cnt     <= 6'd31;
      r_head       <= PREAMBLE[31];
      r_shift_en   <= 1'b1;
`else
      r_sr         <= '0;
      r_sr_cnt     <= '0;
      r_shift_en   <= 1'b0;
`endif
    end else begin
      r_shift_en <= w_issue;
      if (r_shift_en) r_cnt <= r_cnt + 1'b1;
      if (w_miss) r_check_fail <= 1'b1;
      if (w_acc) begin
        r_buf     <= i_bit_data;
        r_buf_vld <= 1'b1;
        r_words   <= r_words + 1'b1;
      end
      if (w_issue) begin
        if (r_sr_cnt != 6'd0) begin
          r_head <= r_sr[31];
          if ((r_sr_cnt == 6'd1) && r_buf_vld) begin
            r_sr      <= r_buf;
            r_sr_cnt  <= 6'd32;
            r_buf_vld <= 1'b0;
          end else begin
            r_sr     <= r_sr << 1;
            r_sr_cnt <= r_sr_cnt - 6'd1;
          end
        end else begin
          r_head    <= r_buf[31];
          r_sr      <= r_buf << 1;
          r_sr_cnt  <= 6'd31;
          r_buf_vld <= 1'b0;
        end
      end
    end
endmodule
